// File: rtl/stream_fifo_enq_scheduler_pkg.sv
// Shared types and helpers for the stream FIFO enqueue scheduler.
// Type widths follow the default configuration constants below.
package stream_fifo_enq_scheduler_pkg;

  localparam int NUM_REQ      = 4;
  localparam int ENQ_WIDTH    = 2;
  localparam int DATA_WIDTH   = 32;
  localparam int STARVE_LIMIT = 7;

  typedef logic [$clog2(NUM_REQ)-1:0]        req_idx_t;
  typedef logic [$clog2(STARVE_LIMIT+1)-1:0] wait_cnt_t;

  // Increment modulo n; also correct for non-power-of-2 requester counts.
  function automatic req_idx_t rr_inc(input req_idx_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end else begin
      return req_idx_t'(32'(idx) + 32'd1);
    end
  endfunction

endpackage

// File: rtl/stream_fifo_enq_scheduler_rr_slot_select.sv
// Combinational scan: starved requester first, then round-robin from the
// pointer, packing valid requesters contiguously onto slots 0..EnqWidth-1.
module stream_fifo_enq_scheduler_rr_slot_select
  import stream_fifo_enq_scheduler_pkg::*;
#(
  parameter int NumReq   = NUM_REQ,
  parameter int EnqWidth = ENQ_WIDTH
) (
  input  logic     [NumReq-1:0]   vld,
  input  req_idx_t                ptr,
  input  logic     [NumReq-1:0]   starved,
  output req_idx_t [EnqWidth-1:0] slot_idx,
  output logic     [EnqWidth-1:0] slot_vld
);

  // Walk the scan order once and hand out slots in order of appearance
  always_comb begin
    int       k;
    req_idx_t idx;
    slot_idx = '0;
    slot_vld = '0;
    k        = 0;
    idx      = ptr;
    for (int r = 0; r < NumReq; r++) begin
      if (starved[r] && vld[r]) begin
        slot_idx[0] = req_idx_t'(r);
        slot_vld[0] = 1'b1;
        k           = 1;
      end else begin
        k = k;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (vld[idx] && !starved[idx] && (k < EnqWidth)) begin
        for (int s = 0; s < EnqWidth; s++) begin
          if (k == s) begin
            slot_idx[s] = idx;
            slot_vld[s] = 1'b1;
          end else begin
            slot_vld[s] = slot_vld[s];
          end
        end
        k = k + 1;
      end else begin
        k = k;
      end
      idx = rr_inc(idx, NumReq);
    end
  end

endmodule

// File: rtl/stream_fifo_enq_scheduler.sv
// Round-robin enqueue scheduler with starvation promotion for a multi-port FIFO.
// Optional performance counters: define STREAM_FIFO_ENQ_SCHED_PERF_EN.
module stream_fifo_enq_scheduler
  import stream_fifo_enq_scheduler_pkg::*;
#(
  parameter int NumReq      = NUM_REQ,
  parameter int EnqWidth    = ENQ_WIDTH,
  parameter int DataWidth   = DATA_WIDTH,
  parameter int StarveLimit = STARVE_LIMIT
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NumReq-1:0]                   req_vld_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_payload_i,
  output logic [NumReq-1:0]                   req_rdy_o,
  output logic [EnqWidth-1:0]                 fifo_enq_vld_o,
  output logic [EnqWidth-1:0][DataWidth-1:0]  fifo_enq_payload_o,
  input  logic [EnqWidth-1:0]                 fifo_enq_rdy_i,
  input  logic                                flush_i
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
  ,
  output logic [31:0]                         perf_fire_cnt_o,
  output logic [31:0]                         perf_stall_cnt_o
`endif
);

  localparam wait_cnt_t Limit = wait_cnt_t'(StarveLimit);

  req_idx_t                     rr_ptr_q;
  req_idx_t                     rr_ptr_d;
  wait_cnt_t [NumReq-1:0]       wait_cnt_q;
  logic      [NumReq-1:0]       starved;
  logic      [NumReq-1:0]       fire;
  req_idx_t  [EnqWidth-1:0]     slot_idx;
  logic      [EnqWidth-1:0]     slot_vld;
  logic                         starved_active;

  // Lowest-index saturated counter wins promotion (descending loop, last write wins)
  always_comb begin
    starved = '0;
    for (int r = NumReq - 1; r >= 0; r--) begin
      if (wait_cnt_q[r] == Limit) begin
        starved    = '0;
        starved[r] = 1'b1;
      end else begin
        starved = starved;
      end
    end
  end

  assign starved_active = |(starved & req_vld_i);

  stream_fifo_enq_scheduler_rr_slot_select #(
    .NumReq   (NumReq),
    .EnqWidth (EnqWidth)
  ) u_slot_select (
    .vld      (req_vld_i),
    .ptr      (rr_ptr_q),
    .starved  (starved),
    .slot_idx (slot_idx),
    .slot_vld (slot_vld)
  );

  // Slot drive and ready return; flush suppresses every handshake
  always_comb begin
    fifo_enq_vld_o     = '0;
    fifo_enq_payload_o = '0;
    req_rdy_o          = '0;
    for (int s = 0; s < EnqWidth; s++) begin
      if (slot_vld[s] && !flush_i) begin
        fifo_enq_vld_o[s]         = 1'b1;
        fifo_enq_payload_o[s]     = req_payload_i[slot_idx[s]];
        req_rdy_o[slot_idx[s]]    = fifo_enq_rdy_i[s];
      end else begin
        fifo_enq_vld_o[s] = 1'b0;
      end
    end
  end

  assign fire = req_vld_i & req_rdy_o;

  // Pointer follows the last fired slot; a promoted slot 0 counts only when alone
  always_comb begin
    logic found;
    found    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int s = 0; s < EnqWidth; s++) begin
      if (fifo_enq_vld_o[s] && fifo_enq_rdy_i[s] && !((s == 0) && starved_active)) begin
        rr_ptr_d = rr_inc(slot_idx[s], NumReq);
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    if (!found && fifo_enq_vld_o[0] && fifo_enq_rdy_i[0]) begin
      rr_ptr_d = rr_inc(slot_idx[0], NumReq);
    end else begin
      rr_ptr_d = rr_ptr_d;
    end
  end

  // Rotation pointer and per-requester wait counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else if (flush_i) begin
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int r = 0; r < NumReq; r++) begin
        if (fire[r] || !req_vld_i[r]) begin
          wait_cnt_q[r] <= '0;
        end else if (wait_cnt_q[r] != Limit) begin
          wait_cnt_q[r] <= wait_cnt_q[r] + 1'b1;
        end else begin
          wait_cnt_q[r] <= wait_cnt_q[r];
        end
      end
    end
  end

`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
  logic [31:0] fire_pop;

  assign fire_pop = 32'($countones(fire));

  // Free-running performance counters, untouched by flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fire_cnt_o  <= 32'd0;
      perf_stall_cnt_o <= 32'd0;
    end else begin
      perf_fire_cnt_o <= perf_fire_cnt_o + fire_pop;
      if ((|req_vld_i) && !(|fire)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end else begin
        perf_stall_cnt_o <= perf_stall_cnt_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo_enq_scheduler.sv
// Table-driven bench for stream_fifo_enq_scheduler (NumReq=4, EnqWidth=2, StarveLimit=2).
module tb_stream_fifo_enq_scheduler;

  localparam int NR = 4;
  localparam int EW = 2;
  localparam int DW = 32;
  localparam int SL = 2;
  localparam int NV = 18;

  typedef struct {
    logic [3:0] vld;
    logic [1:0] rdy;
    logic       flush;
    logic [1:0] e_vld;
    logic [3:0] e_rdy;
    int         s0;
    int         s1;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  e_vld;
    logic [3:0]  e_rdy;
    logic [31:0] p0;
    logic [31:0] p1;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [NR-1:0]              req_vld = '0;
  logic [NR-1:0][DW-1:0]      req_payload;
  logic [NR-1:0]              req_rdy;
  logic [EW-1:0]              enq_vld;
  logic [EW-1:0][DW-1:0]      enq_payload;
  logic [EW-1:0]              enq_rdy = '0;
  logic                       flush = 1'b0;
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
  logic [31:0]                perf_fire;
  logic [31:0]                perf_stall;
  int                         exp_fires = 0;
  int                         exp_stalls = 0;
`endif

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  stream_fifo_enq_scheduler #(
    .NumReq      (NR),
    .EnqWidth    (EW),
    .DataWidth   (DW),
    .StarveLimit (SL)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .req_vld_i          (req_vld),
    .req_payload_i      (req_payload),
    .req_rdy_o          (req_rdy),
    .fifo_enq_vld_o     (enq_vld),
    .fifo_enq_payload_o (enq_payload),
    .fifo_enq_rdy_i     (enq_rdy),
    .flush_i            (flush)
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
    ,
    .perf_fire_cnt_o    (perf_fire),
    .perf_stall_cnt_o   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pay(input int s);
    if (s < 0) return 32'h0000_0000;
    return 32'hA500_0000 | 32'(s);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    req_vld = v.vld;
    enq_rdy = v.rdy;
    flush   = v.flush;
    e.name  = nm;
    e.e_vld = v.e_vld;
    e.e_rdy = v.e_rdy;
    e.p0    = pay(v.s0);
    e.p1    = pay(v.s1);
    sb.push_back(e);
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
    exp_fires += $countones(v.vld & v.e_rdy);
    if ((v.vld != 4'b0000) && ((v.vld & v.e_rdy) == 4'b0000)) exp_stalls++;
`endif
    #1;
    g = sb.pop_front();
    check({g.name, "_enq_vld"}, 32'(enq_vld), 32'(g.e_vld));
    check({g.name, "_req_rdy"}, 32'(req_rdy), 32'(g.e_rdy));
    check({g.name, "_pay0"}, enq_payload[0], g.p0);
    check({g.name, "_pay1"}, enq_payload[1], g.p1);
  endtask

  initial begin
    for (int r = 0; r < NR; r++) req_payload[r] = pay(r);

    //             vld      rdy    fl    e_vld  e_rdy    s0  s1
    vecs[0]  = '{4'b0000, 2'b11, 1'b0, 2'b00, 4'b0000, -1, -1};
    vecs[1]  = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b0011,  0,  1};
    vecs[2]  = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b1100,  2,  3};
    vecs[3]  = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b0011,  0,  1};
    vecs[4]  = '{4'b0100, 2'b11, 1'b0, 2'b01, 4'b0100,  2, -1};
    vecs[5]  = '{4'b1010, 2'b11, 1'b0, 2'b11, 4'b1010,  3,  1};
    vecs[6]  = '{4'b1000, 2'b11, 1'b0, 2'b01, 4'b1000,  3, -1};
    vecs[7]  = '{4'b1111, 2'b01, 1'b0, 2'b11, 4'b0001,  0,  1};
    vecs[8]  = '{4'b1111, 2'b00, 1'b0, 2'b11, 4'b0000,  1,  2};
    vecs[9]  = '{4'b1111, 2'b00, 1'b0, 2'b11, 4'b0000,  1,  2};
    vecs[10] = '{4'b1111, 2'b01, 1'b0, 2'b11, 4'b0001,  0,  1};
    vecs[11] = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b0110,  1,  2};
    vecs[12] = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b1001,  3,  0};
    vecs[13] = '{4'b0110, 2'b01, 1'b0, 2'b11, 4'b0010,  1,  2};
    vecs[14] = '{4'b1111, 2'b11, 1'b1, 2'b00, 4'b0000, -1, -1};
    vecs[15] = '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b0011,  0,  1};
    vecs[16] = '{4'b1111, 2'b10, 1'b0, 2'b11, 4'b1000,  2,  3};
    vecs[17] = '{4'b0001, 2'b11, 1'b0, 2'b01, 4'b0001,  0, -1};

    // Outputs while held in reset with no valid requesters
    #2;
    check("rst_enq_vld", 32'(enq_vld), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_pay0", enq_payload[0], 32'd0);
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
    check("rst_perf_fire", perf_fire, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NV; i++) apply($sformatf("v%0d", i), vecs[i]);

    @(negedge clk);
    req_vld = '0;
    enq_rdy = '0;
    flush   = 1'b0;
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
    #1;
    check("perf_fire_total", perf_fire, 32'(exp_fires));
    check("perf_stall_total", perf_stall, 32'(exp_stalls));
`endif

    // Asynchronous reset mid-cycle, away from any clock edge
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_enq_vld", 32'(enq_vld), 32'd0);
    check("async_rst_req_rdy", 32'(req_rdy), 32'd0);
`ifdef STREAM_FIFO_ENQ_SCHED_PERF_EN
    check("async_rst_perf_fire", perf_fire, 32'd0);
    check("async_rst_perf_stall", perf_stall, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    // Pointer was 1 before reset; a cleared pointer grants {0,1}
    apply("post_rst", '{4'b1111, 2'b11, 1'b0, 2'b11, 4'b0011, 0, 1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
